// File: rtl/pp_accum_pkg.sv
// Shared helpers for the partial-product accumulator bank: width
// calculations and result shaping (saturate or truncate).
package pp_accum_pkg;

    localparam int RES_MAX_W = 64;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int acc_w(input int data_width, input int acc_depth);
        return 2 * data_width + $clog2(acc_depth) + 1;
    endfunction

    // Low data_width bits of the sum; all-ones instead when saturating an
    // out-of-range sum.
    function automatic logic [RES_MAX_W-1:0] shape_result(
        input logic [RES_MAX_W-1:0] sum,
        input int                   data_width,
        input logic                 invalid,
        input bit                   sat_en
    );
        logic [RES_MAX_W-1:0] mask;
        mask = (64'd1 << data_width) - 64'd1;
        return (sat_en && invalid) ? mask : (sum & mask);
    endfunction

endpackage

// File: rtl/pp_accum_bank_if.sv
// Beat-in / result-out handshake bundle for pp_accum_bank.
interface pp_accum_bank_if
    import pp_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4
);
    localparam int CH_W = ch_w(NUM_CH);

    logic                    in_valid;
    logic                    in_ready;
    logic [CH_W-1:0]         in_ch;
    logic [2*DATA_WIDTH-1:0] in_data;
    logic                    in_cin;
    logic                    out_valid;
    logic                    out_ready;
    logic [CH_W-1:0]         out_ch;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_invalid;
    logic                    out_cout;

    modport master (
        output in_valid, in_ch, in_data, in_cin, out_ready,
        input  in_ready, out_valid, out_ch, out_data, out_invalid, out_cout
    );

    modport slave (
        input  in_valid, in_ch, in_data, in_cin, out_ready,
        output in_ready, out_valid, out_ch, out_data, out_invalid, out_cout
    );
endinterface

// File: rtl/pp_accum_lane.sv
// One accumulation channel: running sum plus beat counter. The lane
// exposes the would-be sum of the current beat and whether that beat
// completes the group; the bank decides what to do with it.
module pp_accum_lane
    import pp_accum_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  ACC_DEPTH  = 4,
    localparam int ACC_W      = acc_w(DATA_WIDTH, ACC_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    beat_i,
    input  logic [2*DATA_WIDTH-1:0] data_i,
    input  logic                    cin_i,
    output logic [ACC_W-1:0]        sum_o,
    output logic                    last_o
);
    localparam int CNT_W = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ACC_W has headroom for ACC_DEPTH full-scale beats plus carries, so no wrap.
    assign sum_o  = acc_q + ACC_W'(data_i) + ACC_W'(cin_i);
    assign last_o = (cnt_q == CNT_W'(ACC_DEPTH - 1));

    // Accumulate, or clear for the next group once the final beat arrives.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (beat_i) begin
            if (last_o) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_o;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Lane state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pp_accum_bank.sv
// Multi-channel partial-product accumulator. Beats are routed to a lane by
// channel; the beat that completes a group loads a single shared output
// register. Optional saturation of out-of-range results is enabled by
// defining PP_ACCUM_SAT_EN (default: truncate).
module pp_accum_bank
    import pp_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int ACC_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    pp_accum_bank_if.slave   bus
);
    localparam int ACC_W = acc_w(DATA_WIDTH, ACC_DEPTH);
    localparam int CH_W  = ch_w(NUM_CH);
`ifdef PP_ACCUM_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [ACC_W-1:0]      lane_sum [NUM_CH];
    logic [NUM_CH-1:0]     lane_last;
    logic [ACC_W-1:0]      sel_sum;
    logic                  sel_last;
    logic                  accept;
    logic                  complete;
    logic                  sum_invalid;
    logic                  sum_cout;

    logic                  out_valid_q,   out_valid_d;
    logic [CH_W-1:0]       out_ch_q,      out_ch_d;
    logic [DATA_WIDTH-1:0] out_data_q,    out_data_d;
    logic                  out_invalid_q, out_invalid_d;
    logic                  out_cout_q,    out_cout_d;

    // A held, untaken result blocks input; a result being taken frees the slot this cycle.
    assign bus.in_ready = !(out_valid_q && !bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lane
            pp_accum_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_DEPTH  (ACC_DEPTH)
            ) u_lane (
                .clk    (clk),
                .reset  (reset),
                .beat_i (accept && (bus.in_ch == CH_W'(g))),
                .data_i (bus.in_data),
                .cin_i  (bus.in_cin),
                .sum_o  (lane_sum[g]),
                .last_o (lane_last[g])
            );
        end
    endgenerate

    // Pick the addressed lane's sum and completion flag.
    always_comb begin
        sel_sum  = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.in_ch == CH_W'(i)) begin
                sel_sum  = lane_sum[i];
                sel_last = lane_last[i];
            end
        end
    end

    assign complete    = accept && sel_last;
    assign sum_invalid = |sel_sum[ACC_W-1:DATA_WIDTH];
    assign sum_cout    = |sel_sum[ACC_W-1:2*DATA_WIDTH];

    // Output slot: load on completion (even while the old result leaves), else drain.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_ch_d      = out_ch_q;
        out_data_d    = out_data_q;
        out_invalid_d = out_invalid_q;
        out_cout_d    = out_cout_q;
        if (complete) begin
            out_valid_d   = 1'b1;
            out_ch_d      = bus.in_ch;
            out_data_d    = DATA_WIDTH'(shape_result(RES_MAX_W'(sel_sum), DATA_WIDTH,
                                                     sum_invalid, SAT_EN));
            out_invalid_d = sum_invalid;
            out_cout_d    = sum_cout;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_ch_q      <= '0;
            out_data_q    <= '0;
            out_invalid_q <= 1'b0;
            out_cout_q    <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_ch_q      <= out_ch_d;
            out_data_q    <= out_data_d;
            out_invalid_q <= out_invalid_d;
            out_cout_q    <= out_cout_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_ch      = out_ch_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_invalid = out_invalid_q;
    assign bus.out_cout    = out_cout_q;

endmodule

// File: doc/pp_accum_bank.md
PP_ACCUM_BANK -- requirements
Module: pp_accum_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand width; partial products are 2*DATA_WIDTH bits and results are DATA_WIDTH bits.
REQ-002 SHALL have parameter NUM_CH, default 4: number of independent accumulation channels (>=2).
REQ-003 SHALL have parameter ACC_DEPTH, default 4: partial products summed per result (>=1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: input beat present.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a beat.
REQ-008 SHALL have port in_ch, input, $clog2(NUM_CH) bits: target channel.
REQ-009 SHALL have port in_data, input, 2*DATA_WIDTH bits: partial product.
REQ-010 SHALL have port in_cin, input, 1 bit: carry-in added with the beat.
REQ-011 SHALL have port out_valid, output, 1 bit: result held.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-013 SHALL have port out_ch, output, $clog2(NUM_CH) bits: channel of the held result.
REQ-014 SHALL have port out_data, output, DATA_WIDTH bits: final result.
REQ-015 SHALL have port out_invalid, output, 1 bit: sum does not fit in DATA_WIDTH bits.
REQ-016 SHALL have port out_cout, output, 1 bit: sum overflowed 2*DATA_WIDTH bits.

Function
REQ-017 Beat accepted iff in_valid && in_ready at a rising edge of clk; output transfer occurs iff out_valid && out_ready.
REQ-018 in_ready SHALL be !(out_valid && !out_ready), with no dependence on in_valid or in_ch.
REQ-019 Each channel SHALL hold accumulator acc, ACC_W = 2*DATA_WIDTH + $clog2(ACC_DEPTH) + 1 bits, and beat counter cnt (0..ACC_DEPTH-1).
REQ-020 On acceptance: sum = acc[in_ch] + in_data + in_cin, zero-extended to ACC_W bits, with no wrap.
REQ-021 If cnt[in_ch] < ACC_DEPTH-1: acc <= sum and cnt <= cnt+1.
REQ-022 Otherwise (completing beat): acc <= 0, cnt <= 0, output register loads sum and in_ch, and out_valid <= 1 on that same edge, giving 1-cycle latency.
REQ-023 out_invalid = |sum[ACC_W-1:DATA_WIDTH]; out_cout = |sum[ACC_W-1:2*DATA_WIDTH]. Both SHALL be registered alongside the result.
REQ-024 If a transfer and a completing beat occur on the same edge, the new result SHALL load with out_valid kept at 1, with no bubble.
REQ-025 If a transfer occurs with no completing beat, out_valid <= 0.
REQ-026 While out_valid=1 and out_ready=0, out_ch, out_data, out_invalid and out_cout SHALL hold stable.
REQ-027 Channels SHALL be independent; arbitrary interleaving of in_ch SHALL not affect other channels' acc or cnt.
REQ-028 If ACC_DEPTH=1, every accepted beat SHALL complete a result.

Reset
REQ-029 While reset=1, all acc and cnt SHALL be 0, out_valid=0, out_ch=0, out_data=0, out_invalid=0 and out_cout=0, taking effect immediately regardless of clk.
REQ-030 Reset asserted mid-accumulation SHALL discard all partial sums and any held result; the first post-reset edge with reset=0 behaves as after power-up.

Configuration
REQ-031 With macro PP_ACCUM_SAT_EN defined, out_data SHALL be all-ones when out_invalid=1, else sum[DATA_WIDTH-1:0].
REQ-032 Without PP_ACCUM_SAT_EN, out_data SHALL be sum[DATA_WIDTH-1:0] (truncate); out_invalid and out_cout are computed identically in both builds.

Structure
REQ-033 Package pp_accum_pkg SHALL hold the ACC_W and channel-index-width calculation functions and the saturate/truncate result function.
REQ-034 Per-channel acc and cnt SHALL live in sub-module pp_accum_lane, instantiated NUM_CH times via generate; the output register and handshake logic stay in pp_accum_bank.

Verification (DATA_WIDTH=8, NUM_CH=4, ACC_DEPTH=4)
REQ-035 Reset=1 with random inputs -> out_valid=0, out_data=0, in_ready=1; ch0 needs 4 fresh beats after release.
REQ-036 ch0 beats 10,20,30,40, cin=0, out_ready=1 -> one out_valid pulse the cycle after the 4th beat, out_ch=0, out_data=0x64, out_invalid=0, out_cout=0.
REQ-037 ch1 beats 0x0100 x4 -> sum 0x400, out_invalid=1, out_cout=0; out_data=0xFF with PP_ACCUM_SAT_EN, 0x00 without.
REQ-038 ch2 beats 0xFFFF x4 with cin=1 -> sum 0x40000, out_cout=1, out_invalid=1.
REQ-039 ch3 completes with out_ready=0 -> in_ready=0, outputs stable for 5 cycles, no beat accepted; out_ready=1 -> transfer, in_ready=1 next cycle.
REQ-040 Alternating ch0/ch1 beats (1..8) with out_ready=1 continuously -> ch0 result 16 and ch1 result 20, each on consecutive completions with no bubble.
